// File: rtl/quant_scheduler.sv
// rtl/quant_scheduler.sv - channel-sequenced int8 requantization scheduler with credit-limited output FIFO
// quantizer: sat8(((data*scale)>>>15) + zp), three register stages, no stall.

module quantizer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [31:0] data_in,
    input  logic signed [15:0] scale,
    input  logic signed [7:0]  zero_point,
    output logic signed [7:0]  data_out
);
    logic signed [31:0] s1_data;
    logic signed [15:0] s1_scale;
    logic signed [7:0]  s1_zp;
    logic signed [47:0] s2_shift;
    logic signed [7:0]  s2_zp;
    logic signed [48:0] sum;
    logic signed [7:0]  sat_val;

    always_comb begin
        sum = {s2_shift[47], s2_shift} + {{41{s2_zp[7]}}, s2_zp};
        if (sum > 49'sd127)
            sat_val = 8'sd127;
        else if (sum < -49'sd128)
            sat_val = -8'sd128;
        else
            sat_val = sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_scale <= '0;
            s1_zp    <= '0;
            s2_shift <= '0;
            s2_zp    <= '0;
            data_out <= '0;
        end else begin
            s1_data  <= data_in;
            s1_scale <= scale;
            s1_zp    <= zero_point;
            s2_shift <= (s1_data * s1_scale) >>> 15;
            s2_zp    <= s1_zp;
            data_out <= sat_val;
        end
    end
endmodule

module quant_scheduler #(
    parameter int NUM_CH     = 32,
    parameter int CH_W       = 5,
    parameter int PX_W       = 16,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_addr,
    input  logic signed [15:0] cfg_scale,
    input  logic signed [7:0]  cfg_zp,
    input  logic               start,
    input  logic [CH_W:0]      cfg_num_ch,
    input  logic [PX_W-1:0]    cfg_num_px,
    output logic               busy,
    output logic               done,
    output logic               err_last,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic signed [31:0] acc_data,
    input  logic               acc_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  out_data,
    output logic [CH_W-1:0]    out_ch
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CW      = FIFO_AW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic signed [15:0] scale_tab [NUM_CH];
    logic signed [7:0]  zp_tab    [NUM_CH];

    logic [CH_W:0]      num_ch_r;
    logic [PX_W-1:0]    num_px_r;
    logic [CH_W-1:0]    ch_cnt;
    logic [PX_W-1:0]    px_cnt;
    logic [PX_W-1:0]    px_next;
    logic               ch_is_last;
    logic               pix_end;
    logic               xfer;

    logic [PIPE_LAT-1:0] vp_valid;
    logic [CH_W-1:0]     vp_ch [PIPE_LAT];
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       credit_used;

    logic signed [31:0] q_data_h, q_data;
    logic signed [15:0] q_scale_h, q_scale;
    logic signed [7:0]  q_zp_h, q_zp, q_out;

    logic signed [7:0]  fifo_data [FIFO_DEPTH];
    logic [CH_W-1:0]    fifo_ch   [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               push, pop;

    assign xfer       = acc_valid & acc_ready;
    assign ch_is_last = ({1'b0, ch_cnt} == num_ch_r - (CH_W+1)'(1));
    assign pix_end    = acc_last | ch_is_last;
    assign px_next    = px_cnt + PX_W'(1);
    assign push       = vp_valid[PIPE_LAT-1];
    assign pop        = out_valid & out_ready;

    // Idle cycles keep the quantizer inputs frozen; the valid pipe masks its output.
    assign q_data  = xfer ? acc_data          : q_data_h;
    assign q_scale = xfer ? scale_tab[ch_cnt] : q_scale_h;
    assign q_zp    = xfer ? zp_tab[ch_cnt]    : q_zp_h;

    quantizer u_quantizer (
        .clk        (clk),
        .rst_n      (~rst),
        .data_in    (q_data),
        .scale      (q_scale),
        .zero_point (q_zp),
        .data_out   (q_out)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++)
            inflight = inflight + CW'(vp_valid[i]);
        credit_used = CW'(fifo_cnt) + inflight;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cfg_num_px == '0) ? DRAIN : RUN;
            RUN:     if (xfer && pix_end && px_next == num_px_r) state_nxt = DRAIN;
            DRAIN:   if (vp_valid == '0 && fifo_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Same-cycle pop is deliberately not credited so the FIFO can never overflow.
    always_comb begin
        busy      = (state != IDLE);
        acc_ready = (state == RUN) && (credit_used < CW'(FIFO_DEPTH));
        done      = (state == DRAIN) && (vp_valid == '0) && (fifo_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we) begin
            scale_tab[cfg_addr] <= cfg_scale;
            zp_tab[cfg_addr]    <= cfg_zp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_ch_r  <= '0;
            num_px_r  <= '0;
            ch_cnt    <= '0;
            px_cnt    <= '0;
            err_last  <= 1'b0;
            vp_valid  <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                vp_ch[i] <= '0;
            q_data_h  <= '0;
            q_scale_h <= '0;
            q_zp_h    <= '0;
        end else begin
            if (state == IDLE && start) begin
                num_ch_r <= (cfg_num_ch == '0) ? (CH_W+1)'(NUM_CH) : cfg_num_ch;
                num_px_r <= cfg_num_px;
                ch_cnt   <= '0;
                px_cnt   <= '0;
                err_last <= 1'b0;
            end
            if (xfer) begin
                if (pix_end) begin
                    ch_cnt <= '0;
                    px_cnt <= px_next;
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
                if (acc_last != ch_is_last)
                    err_last <= 1'b1;
                q_data_h  <= q_data;
                q_scale_h <= q_scale;
                q_zp_h    <= q_zp;
            end
            vp_valid <= {vp_valid[PIPE_LAT-2:0], xfer};
            vp_ch[0] <= ch_cnt;
            for (int i = 1; i < PIPE_LAT; i++)
                vp_ch[i] <= vp_ch[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= q_out;
            fifo_ch[wr_ptr]   <= vp_ch[PIPE_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == FIFO_AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == FIFO_AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_ch    = out_valid ? fifo_ch[rd_ptr]   : '0;
endmodule
